imem_loader: RTL and testbench

Serial program loader for the single-cycle RISC-V core. It receives a framed program image over a UART line and writes it word by word into instruction memory through a simple write port. While a load is in progress it holds the CPU in preset, and it reports completion or error when the frame ends. It sits beside the core on the board clock domain and is the write-side counterpart to the core's instruction fetch.

---
 rtl/imem_loader.sv | 272 +++++++++++++++++++++++++++
 tb/tb_imem_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: 8N1 UART receiver plus frame parser that writes a program image into instruction memory and holds the CPU meanwhile.
// Outputs register one cycle after each received byte; no backpressure (the UART cannot stall); LOADER_CHECKSUM_EN adds the trailing XOR byte check.
module imem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]      LEN_MAX   = 32'd1 << ADDR_W;
  localparam logic [7:0]       SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA,
`ifdef LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE, ERR
  } state_t;

  // ---------------- UART receiver ----------------
  rx_state_t        rx_state_q, rx_state_d;
  logic             rx_meta_q, rx_sync_q;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_vld_q, byte_vld_d;
  logic             frame_err_q, frame_err_d;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      // Synchronizer resets to the idle line level so reset release never looks like a start bit.
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    clk_cnt_d   = clk_cnt_q + CNT_W'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d  = '0;
          bit_idx_d  = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          byte_vld_d  = rx_sync_q;
          frame_err_d = !rx_sync_q;
          rx_state_d  = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- Frame parser ----------------
  state_t          state_q, state_d;
  logic [7:0]      len_lo_q, len_lo_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] wcnt_q, wcnt_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [23:0]     wbuf_q, wbuf_d;
  logic            imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]     imem_wdata_q, imem_wdata_d;
  logic            cpu_hold_q, cpu_hold_d;
  logic            busy_q, busy_d;
  logic            load_done_q, load_done_d;
  logic            load_err_q, load_err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      chk_q, chk_d;
`endif

  logic [15:0]     len_word;
  logic [ADDR_W:0] wcnt_inc;
  logic            go_done, go_err, payload_end;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      len_lo_q     <= '0;
      len_q        <= '0;
      wcnt_q       <= '0;
      bcnt_q       <= '0;
      wbuf_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_hold_q   <= 1'b0;
      busy_q       <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      wcnt_q       <= wcnt_d;
      bcnt_q       <= bcnt_d;
      wbuf_q       <= wbuf_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      busy_q       <= busy_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    wcnt_d       = wcnt_q;
    bcnt_d       = bcnt_q;
    wbuf_d       = wbuf_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_hold_d   = cpu_hold_q;
    busy_d       = busy_q;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;
`ifdef LOADER_CHECKSUM_EN
    chk_d        = chk_q;
`endif
    go_done      = 1'b0;
    go_err       = 1'b0;
    payload_end  = 1'b0;
    len_word     = {shift_q, len_lo_q};
    wcnt_inc     = wcnt_q + (ADDR_W+1)'(1);

    if (frame_err_q) begin
      case (state_q)
        IDLE, DONE, ERR: ;
        default: go_err = 1'b1;
      endcase
    end else if (byte_vld_q) begin
      case (state_q)
        IDLE, DONE, ERR: begin
          if (shift_q == SYNC_BYTE) begin
            state_d     = LEN_LO;
            load_done_d = 1'b0;
            load_err_d  = 1'b0;
            busy_d      = 1'b1;
            cpu_hold_d  = 1'b1;
            wcnt_d      = '0;
            bcnt_d      = '0;
`ifdef LOADER_CHECKSUM_EN
            chk_d       = '0;
`endif
          end
        end
        LEN_LO: begin
          len_lo_d = shift_q;
          state_d  = LEN_HI;
        end
        LEN_HI: begin
          len_d = (ADDR_W+1)'(len_word);
          if ({16'd0, len_word} > LEN_MAX) go_err = 1'b1;
          else if (len_word == 16'd0)      payload_end = 1'b1;
          else                             state_d = DATA;
        end
        DATA: begin
          // Little-endian assembly: the newest byte enters at the top.
          bcnt_d = bcnt_q + 2'd1;
          wbuf_d = {shift_q, wbuf_q[23:8]};
`ifdef LOADER_CHECKSUM_EN
          chk_d  = chk_q ^ shift_q;
`endif
          if (bcnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = wcnt_q[ADDR_W-1:0];
            imem_wdata_d = {shift_q, wbuf_q};
            wcnt_d       = wcnt_inc;
            if (wcnt_inc == len_q) payload_end = 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: begin
          if (shift_q == chk_q) go_done = 1'b1;
          else                  go_err  = 1'b1;
        end
`endif
        default: ;
      endcase
    end

`ifdef LOADER_CHECKSUM_EN
    if (payload_end) state_d = CHK;
`else
    if (payload_end) go_done = 1'b1;
`endif

    if (go_done) begin
      state_d     = DONE;
      load_done_d = 1'b1;
      busy_d      = 1'b0;
      cpu_hold_d  = 1'b0;
    end
    // A failed load leaves the CPU held so it never runs a partial image.
    if (go_err) begin
      state_d    = ERR;
      load_err_d = 1'b1;
      busy_d     = 1'b0;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign busy       = busy_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: UART-driven frames with hand-computed expected writes and flags.
module tb_imem_loader;

  localparam int CPB = 16;
  localparam int AW  = 8;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif
  localparam logic [31:0] W0 = 32'h0050_0093;
  localparam logic [31:0] W1 = 32'h00A0_0113;
  // 93^00^50^00^13^01^A0^00
  localparam logic [7:0]  CHK_GOOD = 8'h71;

  logic          clk_in = 1'b0;
  logic          rst    = 1'b1;
  logic          rx     = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold, busy, load_done, load_err;

  imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .rx        (rx),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write monitor, sampled on the falling edge.
  logic [31:0] wr_addr[$];
  logic [31:0] wr_dat[$];
  int          we_long   = 0;
  logic        we_prev   = 1'b0;
  logic        done_prev = 1'b0;
  int unsigned done_rise = 0;
  int unsigned last_start = 0;

  always @(negedge clk_in) begin
    if (imem_we) begin
      wr_addr.push_back(32'(imem_addr));
      wr_dat.push_back(imem_wdata);
      if (we_prev) we_long++;
    end
    if (load_done && !done_prev) done_rise = cyc;
    we_prev   = imem_we;
    done_prev = load_done;
  end

  task automatic clear_writes();
    wr_addr.delete();
    wr_dat.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    @(negedge clk_in);
    last_start = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk_in);
    end
    rx = stop;
    repeat (CPB) @(negedge clk_in);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_prog(input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(W0);
    send_word(W1);
    send_byte(chk);
  endtask

  task automatic check_two_writes(input string tag);
    expect_eq({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
    for (int i = 0; i < 2; i++) begin
      expect_eq($sformatf("%s_addr%0d", tag, i),
                (i < wr_addr.size()) ? wr_addr[i] : 32'hFFFF_FFFF, 32'(i));
      expect_eq($sformatf("%s_data%0d", tag, i),
                (i < wr_dat.size()) ? wr_dat[i] : 32'hFFFF_FFFF, (i == 0) ? W0 : W1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    expect_eq({tag, "_we"},    32'(imem_we),   32'd0);
    expect_eq({tag, "_addr"},  32'(imem_addr), 32'd0);
    expect_eq({tag, "_wdata"}, imem_wdata,     32'd0);
    expect_eq({tag, "_hold"},  32'(cpu_hold),  32'd0);
    expect_eq({tag, "_busy"},  32'(busy),      32'd0);
    expect_eq({tag, "_done"},  32'(load_done), 32'd0);
    expect_eq({tag, "_err"},   32'(load_err),  32'd0);
  endtask

  initial begin
    int unsigned t_ref;
    int unsigned offs;

    repeat (3) @(negedge clk_in);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2*CPB) @(negedge clk_in);

    // Good two-word frame.
    clear_writes();
    send_byte(8'hA5);
    expect_eq("t1_busy_hdr", 32'(busy), 32'd1);
    expect_eq("t1_hold_hdr", 32'(cpu_hold), 32'd1);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(W0);
    send_word(W1);
    send_byte(CHK_GOOD);
    check_two_writes("t1");
    expect_eq("t1_we_width", 32'(we_long), 32'd0);
    expect_eq("t1_done", 32'(load_done), 32'd1);
    expect_eq("t1_err",  32'(load_err),  32'd0);
    expect_eq("t1_hold", 32'(cpu_hold),  32'd0);
    expect_eq("t1_busy", 32'(busy),      32'd0);

    // Corrupted checksum byte: only fatal when the check is compiled in.
    clear_writes();
    send_prog(CHK_GOOD ^ 8'h01);
    check_two_writes("t2");
    expect_eq("t2_done", 32'(load_done), CHK_ON ? 32'd0 : 32'd1);
    expect_eq("t2_err",  32'(load_err),  CHK_ON ? 32'd1 : 32'd0);
    expect_eq("t2_hold", 32'(cpu_hold),  CHK_ON ? 32'd1 : 32'd0);
    expect_eq("t2_busy", 32'(busy),      32'd0);

    // Zero-length frame.
    clear_writes();
    send_byte(8'hA5);
    expect_eq("t3_done_clr", 32'(load_done), 32'd0);
    expect_eq("t3_err_clr",  32'(load_err),  32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    t_ref = last_start;
    send_byte(8'h00);
    if (CHK_ON) t_ref = last_start;
    offs = done_rise - t_ref;
    expect_eq("t3_nwr", 32'(wr_addr.size()), 32'd0);
    expect_eq("t3_done", 32'(load_done), 32'd1);
    expect_eq("t3_done_time", 32'((offs > 9*CPB) && (offs <= 10*CPB)), 32'd1);

    // Oversized length N=257.
    clear_writes();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    expect_eq("t4_err",  32'(load_err),  32'd1);
    expect_eq("t4_busy", 32'(busy),      32'd0);
    expect_eq("t4_hold", 32'(cpu_hold),  32'd1);
    expect_eq("t4_done", 32'(load_done), 32'd0);
    send_word(32'h4433_2211);
    expect_eq("t4_nwr", 32'(wr_addr.size()), 32'd0);

    // Glitch then framing error mid-payload.
    clear_writes();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    expect_eq("t5_busy", 32'(busy), 32'd1);
    @(negedge clk_in);
    rx = 1'b0;
    repeat (5) @(negedge clk_in);
    rx = 1'b1;
    repeat (2*CPB) @(negedge clk_in);
    send_word(32'hDEAD_BEEF);
    expect_eq("t5_nwr1", 32'(wr_addr.size()), 32'd1);
    expect_eq("t5_wdata", (wr_dat.size() > 0) ? wr_dat[0] : 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    expect_eq("t5_err_pre", 32'(load_err), 32'd0);
    send_byte(8'h3C, 1'b0);
    repeat (2*CPB) @(negedge clk_in);
    expect_eq("t5_err",  32'(load_err),  32'd1);
    expect_eq("t5_busy_end", 32'(busy),  32'd0);
    expect_eq("t5_hold", 32'(cpu_hold),  32'd1);
    expect_eq("t5_nwr2", 32'(wr_addr.size()), 32'd1);

    // Reset in the middle of word 1, then a clean reload.
    clear_writes();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(W0);
    send_byte(8'h13);
    send_byte(8'h01);
    expect_eq("t6_hold_pre", 32'(cpu_hold), 32'd1);
    @(negedge clk_in);
    rst = 1'b1;
    #1;
    check_all_zero("t6_rst");
    repeat (4) @(negedge clk_in);
    rst = 1'b0;
    repeat (2*CPB) @(negedge clk_in);
    clear_writes();
    send_prog(CHK_GOOD);
    check_two_writes("t6");
    expect_eq("t6_done", 32'(load_done), 32'd1);
    expect_eq("t6_hold", 32'(cpu_hold),  32'd0);
    expect_eq("t6_we_width", 32'(we_long), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
